// File: rtl/spsram_arbiter_if.sv
// spsram_arbiter_if: one requester port (request + response) of the SRAM arbiter
// master: requester side (drives req_*, receives req_ready and rsp_*)
// slave:  arbiter side (receives req_*, drives req_ready and rsp_*)
interface spsram_arbiter_if #(parameter int AW = 11, parameter int NBITS = 32);
  logic req_valid, req_ready, req_lock, rsp_valid;
  logic [AW-1:0] req_addr;
  logic [NBITS-1:0] req_wdata, rsp_rdata;
  logic [3:0] req_we;
  modport master(output req_valid, req_addr, req_wdata, req_we, req_lock, input req_ready, rsp_valid, rsp_rdata);
  modport slave(input req_valid, req_addr, req_wdata, req_we, req_lock, output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/spsram_arbiter.sv
// spsram_arbiter: round-robin two-port arbiter with lock in front of a single-port SRAM
// clock/resetn: rising-edge clock, async active-low reset
// p0/p1: requester ports (fetch, load/store); combinational ready, response one cycle after accept
// sram_addr/sram_data/sram_we: SRAM request, driven from the granted port; sram_out_data: registered read data
module spsram_arbiter #(
  parameter int NBITS = 32,
  parameter int LENGTH = 8192,
  localparam int AW = $clog2(LENGTH / 4)
) (
  input  logic             clock,
  input  logic             resetn,
  spsram_arbiter_if.slave  p0,
  spsram_arbiter_if.slave  p1,
  output logic [AW-1:0]    sram_addr,
  output logic [NBITS-1:0] sram_data,
  output logic [3:0]       sram_we,
  input  logic [NBITS-1:0] sram_out_data
);
  typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;
  state_t state;
  logic last_grant, rsp_pending, rsp_tag, g0, g1;
  logic [AW-1:0] addr_q;
  // A tie in FREE goes to the port that was not granted last; grants are held off while in reset.
  always_comb begin
    g0 = resetn & p0.req_valid & (state == OWN0 | state == FREE & (!p1.req_valid | last_grant));
    g1 = resetn & p1.req_valid & (state == OWN1 | state == FREE & (!p0.req_valid | !last_grant));
    sram_addr = g0 ? p0.req_addr : g1 ? p1.req_addr : addr_q;
    sram_data = g1 ? p1.req_wdata : p0.req_wdata;
    sram_we = g0 ? p0.req_we : g1 ? p1.req_we : 4'b0;
  end
  assign p0.req_ready = g0;
  assign p1.req_ready = g1;
  assign p0.rsp_valid = rsp_pending & !rsp_tag;
  assign p1.rsp_valid = rsp_pending & rsp_tag;
  assign p0.rsp_rdata = sram_out_data;
  assign p1.rsp_rdata = sram_out_data;
  // addr_q keeps the SRAM address steady on idle cycles so its registered output does not change.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= FREE;
      last_grant <= 1'b1;
      rsp_pending <= 1'b0;
      rsp_tag <= 1'b0;
      addr_q <= '0;
    end else begin
      rsp_pending <= g0 | g1;
      if (g0 | g1) begin
        last_grant <= g1;
        rsp_tag <= g1;
        addr_q <= sram_addr;
        state <= g0 ? (p0.req_lock ? OWN0 : FREE) : (p1.req_lock ? OWN1 : FREE);
      end
    end
endmodule

// File: tb/tb_spsram_arbiter.sv
// tb_spsram_arbiter: directed self-checking bench for spsram_arbiter with a read-before-write SRAM model
module tb_spsram_arbiter;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [10:0] sram_addr;
  logic [31:0] sram_data, sram_out_data;
  logic [3:0] sram_we;
  logic bd_we = 1'b0;
  logic [10:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] mem [0:2047];
  int checks = 0;
  int errors = 0;

  spsram_arbiter_if #(.AW(11), .NBITS(32)) p0_if();
  spsram_arbiter_if #(.AW(11), .NBITS(32)) p1_if();

  spsram_arbiter #(.NBITS(32), .LENGTH(8192)) dut (
    .clock(clock), .resetn(resetn), .p0(p0_if.slave), .p1(p1_if.slave),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_we(sram_we), .sram_out_data(sram_out_data)
  );

  always #5 clock = ~clock;

  // Registered read of the old contents, byte-lane writes at the same edge; bd_* is a preload path.
  always @(posedge clock) begin
    sram_out_data <= mem[sram_addr];
    if (bd_we) mem[bd_addr] <= bd_data;
    else for (int b = 0; b < 4; b++) if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_data[8*b +: 8];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    p0_if.req_valid = 0; p0_if.req_addr = '0; p0_if.req_wdata = '0; p0_if.req_we = '0; p0_if.req_lock = 0;
    p1_if.req_valid = 0; p1_if.req_addr = '0; p1_if.req_wdata = '0; p1_if.req_we = '0; p1_if.req_lock = 0;
  endtask

  task automatic preload();
    logic [10:0] a [5] = '{11'd5, 11'd3, 11'd7, 11'd10, 11'd20};
    logic [31:0] d [5] = '{32'hDEADBEEF, 32'h11223344, 32'h77777777, 32'hA0A0A010, 32'hB0B0B020};
    for (int i = 0; i < 5; i++) begin
      bd_we = 1; bd_addr = a[i]; bd_data = d[i];
      tick();
    end
    bd_we = 0;
  endtask

  task automatic test_reset();
    p0_if.req_valid = 1; p0_if.req_addr = 11'd9; p0_if.req_we = 4'hF;
    p1_if.req_valid = 1; p1_if.req_addr = 11'd4;
    #1;
    checks++; if (sram_we !== 4'h0) begin errors++; $display("FAIL reset_we: got %h expected 0", sram_we); end
    checks++; if (sram_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
    checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_p0_rsp: got %b expected 0", p0_if.rsp_valid); end
    checks++; if (p1_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_p1_rsp: got %b expected 0", p1_if.rsp_valid); end
    idle();
    tick();
    resetn = 1;
    #1;
  endtask

  task automatic test_contention();
    logic [31:0] exp;
    p0_if.req_valid = 1; p0_if.req_addr = 11'd10;
    p1_if.req_valid = 1; p1_if.req_addr = 11'd20;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (p0_if.req_ready !== (i % 2 == 0)) begin errors++; $display("FAIL cont_p0_ready[%0d]: got %b expected %b", i, p0_if.req_ready, i % 2 == 0); end
      checks++; if (p1_if.req_ready !== (i % 2 == 1)) begin errors++; $display("FAIL cont_p1_ready[%0d]: got %b expected %b", i, p1_if.req_ready, i % 2 == 1); end
      tick();
      exp = (i % 2 == 0) ? 32'hA0A0A010 : 32'hB0B0B020;
      checks++; if (p0_if.rsp_valid !== (i % 2 == 0)) begin errors++; $display("FAIL cont_p0_rsp[%0d]: got %b expected %b", i, p0_if.rsp_valid, i % 2 == 0); end
      checks++; if (p1_if.rsp_valid !== (i % 2 == 1)) begin errors++; $display("FAIL cont_p1_rsp[%0d]: got %b expected %b", i, p1_if.rsp_valid, i % 2 == 1); end
      checks++; if (p0_if.rsp_rdata !== exp) begin errors++; $display("FAIL cont_rdata[%0d]: got %h expected %h", i, p0_if.rsp_rdata, exp); end
    end
    idle();
    tick();
  endtask

  task automatic test_single_read();
    p0_if.req_valid = 1; p0_if.req_addr = 11'd5;
    #1;
    checks++; if (p0_if.req_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", p0_if.req_ready); end
    checks++; if (sram_addr !== 11'd5) begin errors++; $display("FAIL single_addr: got %h expected 5", sram_addr); end
    tick();
    p0_if.req_valid = 0; p0_if.req_addr = 11'd0;
    #1;
    checks++; if (p0_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp: got %b expected 1", p0_if.rsp_valid); end
    checks++; if (p0_if.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h expected deadbeef", p0_if.rsp_rdata); end
    checks++; if (p1_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_p1_rsp: got %b expected 0", p1_if.rsp_valid); end
    checks++; if (sram_addr !== 11'd5) begin errors++; $display("FAIL single_addr_hold: got %h expected 5", sram_addr); end
    tick();
    checks++; if (p0_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", p0_if.rsp_valid); end
  endtask

  task automatic test_byte_write();
    p1_if.req_valid = 1; p1_if.req_addr = 11'd3; p1_if.req_wdata = 32'hAABBCCDD; p1_if.req_we = 4'b0101;
    #1;
    checks++; if (p1_if.req_ready !== 1'b1) begin errors++; $display("FAIL bw_ready: got %b expected 1", p1_if.req_ready); end
    checks++; if (sram_we !== 4'b0101) begin errors++; $display("FAIL bw_we: got %b expected 0101", sram_we); end
    checks++; if (sram_data !== 32'hAABBCCDD) begin errors++; $display("FAIL bw_data: got %h expected aabbccdd", sram_data); end
    tick();
    p1_if.req_we = 4'b0000;
    #1;
    checks++; if (p1_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL bw_wrsp: got %b expected 1", p1_if.rsp_valid); end
    checks++; if (p1_if.rsp_rdata !== 32'h11223344) begin errors++; $display("FAIL bw_old: got %h expected 11223344", p1_if.rsp_rdata); end
    checks++; if (p1_if.req_ready !== 1'b1) begin errors++; $display("FAIL bw_rd_ready: got %b expected 1", p1_if.req_ready); end
    tick();
    idle();
    #1;
    checks++; if (p1_if.rsp_rdata !== 32'h11BB33DD) begin errors++; $display("FAIL bw_new: got %h expected 11bb33dd", p1_if.rsp_rdata); end
    tick();
  endtask

  task automatic test_lock();
    p0_if.req_valid = 1; p0_if.req_addr = 11'd10;
    tick();
    p1_if.req_valid = 1; p1_if.req_addr = 11'd7; p1_if.req_lock = 1;
    #1;
    checks++; if (p1_if.req_ready !== 1'b1) begin errors++; $display("FAIL lock_p1_ready: got %b expected 1", p1_if.req_ready); end
    checks++; if (p0_if.req_ready !== 1'b0) begin errors++; $display("FAIL lock_p0_tie: got %b expected 0", p0_if.req_ready); end
    tick();
    p1_if.req_valid = 0;
    #1;
    checks++; if (p0_if.req_ready !== 1'b0) begin errors++; $display("FAIL lock_p0_idle_owner: got %b expected 0", p0_if.req_ready); end
    checks++; if (p1_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL lock_rd_rsp: got %b expected 1", p1_if.rsp_valid); end
    checks++; if (p1_if.rsp_rdata !== 32'h77777777) begin errors++; $display("FAIL lock_rd_data: got %h expected 77777777", p1_if.rsp_rdata); end
    tick();
    p1_if.req_valid = 1; p1_if.req_wdata = 32'h12345678; p1_if.req_we = 4'hF; p1_if.req_lock = 0;
    #1;
    checks++; if (p1_if.req_ready !== 1'b1) begin errors++; $display("FAIL lock_wr_ready: got %b expected 1", p1_if.req_ready); end
    checks++; if (p0_if.req_ready !== 1'b0) begin errors++; $display("FAIL lock_p0_wr: got %b expected 0", p0_if.req_ready); end
    tick();
    p1_if.req_valid = 0; p1_if.req_we = 4'h0;
    #1;
    checks++; if (p0_if.req_ready !== 1'b1) begin errors++; $display("FAIL lock_release: got %b expected 1", p0_if.req_ready); end
    checks++; if (p1_if.rsp_rdata !== 32'h77777777) begin errors++; $display("FAIL lock_wr_old: got %h expected 77777777", p1_if.rsp_rdata); end
    tick();
    checks++; if (p0_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL lock_p0_rsp: got %b expected 1", p0_if.rsp_valid); end
    checks++; if (mem[7] !== 32'h12345678) begin errors++; $display("FAIL lock_mem7: got %h expected 12345678", mem[7]); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    p1_if.req_valid = 1; p1_if.req_addr = 11'd7; p1_if.req_lock = 1;
    #1;
    checks++; if (p1_if.req_ready !== 1'b1) begin errors++; $display("FAIL rmid_accept: got %b expected 1", p1_if.req_ready); end
    tick();
    p0_if.req_valid = 1; p0_if.req_addr = 11'd10;
    p1_if.req_lock = 0;
    resetn = 0;
    #1;
    checks++; if (p1_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_drop: got %b expected 0", p1_if.rsp_valid); end
    checks++; if (sram_we !== 4'h0) begin errors++; $display("FAIL rmid_we: got %b expected 0", sram_we); end
    tick();
    resetn = 1;
    #1;
    checks++; if (p0_if.req_ready !== 1'b1) begin errors++; $display("FAIL rmid_p0_first: got %b expected 1", p0_if.req_ready); end
    checks++; if (p1_if.req_ready !== 1'b0) begin errors++; $display("FAIL rmid_p1_wait: got %b expected 0", p1_if.req_ready); end
    tick();
    checks++; if (p0_if.rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_p0_rsp: got %b expected 1", p0_if.rsp_valid); end
    idle();
    tick();
  endtask

  initial begin
    idle();
    preload();
    test_reset();
    test_contention();
    test_single_read();
    test_byte_write();
    test_lock();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
